// File: rtl/vsync_monitor.sv
// vsync_monitor: measures vsync/display_active segment timing per frame,
// flags out-of-tolerance or illegal segments and reports frame lock.
// Ports: clk, reset (sync, active-low), vsync_in (low = pulse),
//   display_active_in -> locked, frame_done, frame_count[7:0],
//   timing_error, err_code[2:0], row[6:0], row_valid.
// Optional: define VSYNC_MONITOR_ROW_TRACK_EN to build the row tracker;
//   without it row and row_valid are tied low.
module vsync_monitor #(
   parameter int unsigned VSYNC_PULSE_WIDTH_TIME = 6400,
   parameter int unsigned BACK_PORCH_TIME        = 92800,
   parameter int unsigned ACTIVE_VIDEO_TIME      = 1536000,
   parameter int unsigned FRONT_PORCH_TIME       = 32000,
   parameter int unsigned LINE_TIME              = 16000,
   parameter int unsigned TOLERANCE              = 16,
   parameter int unsigned CNT_WIDTH              = 22
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       vsync_in,
   input  logic       display_active_in,
   output logic       locked,
   output logic       frame_done,
   output logic [7:0] frame_count,
   output logic       timing_error,
   output logic [2:0] err_code,
   output logic [6:0] row,
   output logic       row_valid
);

   typedef enum logic [2:0] {
      S_SEEK, S_PULSE, S_BP, S_ACT, S_FP
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   state_t               r_state;
   state_t               w_next;
   logic                 r_vs, r_vs_d;
   logic                 r_da, r_da_d;
   logic [CNT_WIDTH-1:0] r_cnt;
   logic                 r_bad;
   logic                 r_good_one;
   logic                 r_locked;
   logic                 r_fdone;
   logic [7:0]           r_fc;
   logic                 r_terr;
   logic [2:0]           r_code;

   logic                 w_vs_fall, w_vs_rise;
   logic                 w_da_fall, w_da_rise;
   logic                 w_da_hi;
   logic                 w_illegal;
   logic [CNT_WIDTH:0]   w_meas;
   logic                 w_err;
   logic                 w_abort;
   logic [2:0]           w_code;
   logic                 w_fdone;
   logic                 w_new_frame;

   function automatic logic f_in_tol(
      input logic [CNT_WIDTH:0] meas,
      input logic [31:0]        exp_v
   );
      logic [33:0] m;
      logic [33:0] e;
      m = 34'(meas);
      e = 34'(exp_v);
      return (m + 34'(TOLERANCE) >= e) &&
             (m <= e + 34'(TOLERANCE));
   endfunction

   assign w_vs_fall = r_vs_d & ~r_vs;
   assign w_vs_rise = ~r_vs_d & r_vs;
   assign w_da_fall = r_da_d & ~r_da;
   assign w_da_rise = ~r_da_d & r_da;
   // Either side of a display_active fall counts as "high", so a vsync
   // edge coinciding with that fall is caught as illegal.
   assign w_da_hi   = r_da | r_da_d;
   assign w_illegal = (w_da_rise && r_state != S_BP) ||
                      ((w_vs_fall || w_vs_rise) && w_da_hi);
   // The counter is cleared on the transition cycle, so add one to get
   // the full segment length in clocks.
   assign w_meas    = {1'b0, r_cnt} + (CNT_WIDTH+1)'(1);

   always_comb begin
      w_next      = r_state;
      w_err       = 1'b0;
      w_abort     = 1'b0;
      w_code      = 3'd0;
      w_fdone     = 1'b0;
      w_new_frame = 1'b0;
      if (r_state != S_SEEK && w_illegal) begin
         w_next  = S_SEEK;
         w_err   = 1'b1;
         w_abort = 1'b1;
         w_code  = 3'd5;
      end else if (r_state != S_SEEK && r_cnt == CNT_MAX) begin
         w_next  = S_SEEK;
         w_err   = 1'b1;
         w_abort = 1'b1;
         w_code  = 3'd6;
      end else begin
         unique case (r_state)
            S_SEEK: begin
               if (w_vs_fall && !w_da_hi) begin
                  w_next      = S_PULSE;
                  w_new_frame = 1'b1;
               end
            end
            S_PULSE: begin
               if (w_vs_rise) begin
                  w_next = S_BP;
                  if (!f_in_tol(w_meas, 32'(VSYNC_PULSE_WIDTH_TIME))) begin
                     w_err  = 1'b1;
                     w_code = 3'd1;
                  end
               end
            end
            S_BP: begin
               if (w_da_rise) begin
                  w_next = S_ACT;
                  if (!f_in_tol(w_meas, 32'(BACK_PORCH_TIME))) begin
                     w_err  = 1'b1;
                     w_code = 3'd2;
                  end
               end
            end
            S_ACT: begin
               if (w_da_fall) begin
                  w_next = S_FP;
                  if (!f_in_tol(w_meas, 32'(ACTIVE_VIDEO_TIME))) begin
                     w_err  = 1'b1;
                     w_code = 3'd3;
                  end
               end
            end
            S_FP: begin
               if (w_vs_fall) begin
                  w_next      = S_PULSE;
                  w_fdone     = 1'b1;
                  w_new_frame = 1'b1;
                  if (!f_in_tol(w_meas, 32'(FRONT_PORCH_TIME))) begin
                     w_err  = 1'b1;
                     w_code = 3'd4;
                  end
               end
            end
            default: w_next = S_SEEK;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state    <= S_SEEK;
         r_vs       <= 1'b0;
         r_vs_d     <= 1'b0;
         r_da       <= 1'b0;
         r_da_d     <= 1'b0;
         r_cnt      <= '0;
         r_bad      <= 1'b0;
         r_good_one <= 1'b0;
         r_locked   <= 1'b0;
         r_fdone    <= 1'b0;
         r_fc       <= 8'd0;
         r_terr     <= 1'b0;
         r_code     <= 3'd0;
      end else begin
         r_vs    <= vsync_in;
         r_vs_d  <= r_vs;
         r_da    <= display_active_in;
         r_da_d  <= r_da;
         r_state <= w_next;
         if (w_next != r_state) begin
            r_cnt <= '0;
         end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
         end
         r_fdone <= w_fdone;
         r_terr  <= w_err;
         if (w_err) begin
            r_code <= w_code;
         end
         if (w_fdone) begin
            r_fc <= r_fc + 8'd1;
         end
         if (w_new_frame) begin
            r_bad <= 1'b0;
         end else if (w_err) begin
            r_bad <= 1'b1;
         end
         // A failed check drops lock at once; the frame closing with a
         // clean record is what advances the good-frame count.
         if (w_err) begin
            r_good_one <= 1'b0;
            r_locked   <= 1'b0;
         end else if (w_fdone && !r_bad) begin
            r_good_one <= 1'b1;
            if (r_good_one) begin
               r_locked <= 1'b1;
            end
         end
      end
   end

   assign locked       = r_locked;
   assign frame_done   = r_fdone;
   assign frame_count  = r_fc;
   assign timing_error = r_terr;
   assign err_code     = r_code;

`ifdef VSYNC_MONITOR_ROW_TRACK_EN
   localparam int LW = (LINE_TIME > 1) ? $clog2(LINE_TIME) : 1;

   logic [LW-1:0] r_line;
   logic [6:0]    r_row;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_line <= '0;
         r_row  <= 7'd0;
      end else if (r_state != S_ACT) begin
         r_line <= '0;
         r_row  <= 7'd0;
      end else if (r_line == LW'(LINE_TIME - 1)) begin
         r_line <= '0;
         if (r_row != 7'd127) begin
            r_row <= r_row + 7'd1;
         end
      end else begin
         r_line <= r_line + LW'(1);
      end
   end

   assign row       = r_row;
   assign row_valid = (r_state == S_ACT);
`else
   logic w_unused_line;
   assign w_unused_line = (LINE_TIME == 0);
   assign row           = 7'd0;
   assign row_valid     = 1'b0;
`endif

endmodule

// File: tb/tb_vsync_monitor.sv
// tb_vsync_monitor: table frames, random frames and hand sequences for
// vsync_monitor, checked against a segment-level reference model.
module tb_vsync_monitor;

   localparam int PW  = 20;
   localparam int BP  = 30;
   localparam int AV  = 80;
   localparam int FP  = 25;
   localparam int LT  = 10;
   localparam int TOL = 2;
   localparam int CW  = 10;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       vsync_in = 1'b1;
   logic       display_active_in = 1'b0;
   logic       locked;
   logic       frame_done;
   logic [7:0] frame_count;
   logic       timing_error;
   logic [2:0] err_code;
   logic [6:0] row;
   logic       row_valid;

   vsync_monitor #(
      .VSYNC_PULSE_WIDTH_TIME(PW),
      .BACK_PORCH_TIME(BP),
      .ACTIVE_VIDEO_TIME(AV),
      .FRONT_PORCH_TIME(FP),
      .LINE_TIME(LT),
      .TOLERANCE(TOL),
      .CNT_WIDTH(CW)
   ) dut (
      .clk(clk),
      .reset(reset),
      .vsync_in(vsync_in),
      .display_active_in(display_active_in),
      .locked(locked),
      .frame_done(frame_done),
      .frame_count(frame_count),
      .timing_error(timing_error),
      .err_code(err_code),
      .row(row),
      .row_valid(row_valid)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   int mon_fd = 0;
   int mon_te = 0;
   int rv_run = 0;
   int rv_max = 0;
   int rv_last_run = 0;
   int rv_last_max = 0;

   always @(negedge clk) begin
      if (frame_done) mon_fd++;
      if (timing_error) mon_te++;
      if (row_valid) begin
         rv_run++;
         if (int'(row) > rv_max) rv_max = int'(row);
      end else if (rv_run != 0) begin
         rv_last_run = rv_run;
         rv_last_max = rv_max;
         rv_run = 0;
         rv_max = 0;
      end
   end

   // Reference model: one call per observed segment boundary.
   int   m_fd = 0;
   int   m_te = 0;
   int   m_fc = 0;
   int   m_good = 0;
   int   m_err = 0;
   int   m_prev_f = FP;
   logic m_locked = 1'b0;
   logic m_synced = 1'b0;
   logic m_bad = 1'b0;

   function automatic void m_seg(int code, int len, int expv);
      if (len > expv + TOL || len < expv - TOL) begin
         m_te++;
         m_err = code;
         m_bad = 1'b1;
         m_locked = 1'b0;
         m_good = 0;
      end
   endfunction

   function automatic void m_vfall();
      if (m_synced) begin
         m_seg(4, m_prev_f, FP);
         m_fd++;
         m_fc = (m_fc + 1) % 256;
         if (!m_bad) begin
            m_good++;
            if (m_good >= 2) m_locked = 1'b1;
         end
      end
      m_synced = 1'b1;
      m_bad = 1'b0;
   endfunction

   function automatic void m_abort(int code);
      m_te++;
      m_err = code;
      m_locked = 1'b0;
      m_good = 0;
      m_synced = 1'b0;
   endfunction

   function automatic void m_reset();
      m_locked = 1'b0;
      m_fc = 0;
      m_err = 0;
      m_good = 0;
      m_synced = 1'b0;
      m_bad = 1'b0;
   endfunction

   task automatic chk(input string name, input int act, input int expv);
      n_chk++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_all(input string tag);
      chk({tag, "/frame_done_cnt"}, mon_fd, m_fd);
      chk({tag, "/timing_err_cnt"}, mon_te, m_te);
      chk({tag, "/locked"}, int'(locked), int'(m_locked));
      chk({tag, "/err_code"}, int'(err_code), m_err);
      chk({tag, "/frame_count"}, int'(frame_count), m_fc);
`ifndef VSYNC_MONITOR_ROW_TRACK_EN
      chk({tag, "/row"}, int'(row), 0);
      chk({tag, "/row_valid"}, int'(row_valid), 0);
`endif
   endtask

   task automatic frame(input int p, input int b, input int a, input int f);
      vsync_in = 1'b0;
      display_active_in = 1'b0;
      m_vfall();
      step(3);
      check_all("vfall");
      step(p - 3);
      vsync_in = 1'b1;
      m_seg(1, p, PW);
      step(3);
      check_all("pulse");
      step(b - 3);
      display_active_in = 1'b1;
      m_seg(2, b, BP);
      step(3);
      check_all("bporch");
      step(a - 3);
      display_active_in = 1'b0;
      m_seg(3, a, AV);
      step(3);
      check_all("active");
      step(f - 3);
      m_prev_f = f;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "/locked"}, int'(locked), 0);
      chk({tag, "/frame_done"}, int'(frame_done), 0);
      chk({tag, "/frame_count"}, int'(frame_count), 0);
      chk({tag, "/timing_error"}, int'(timing_error), 0);
      chk({tag, "/err_code"}, int'(err_code), 0);
      chk({tag, "/row"}, int'(row), 0);
      chk({tag, "/row_valid"}, int'(row_valid), 0);
   endtask

   typedef struct {
      int p;
      int b;
      int a;
      int f;
      int err;
      int lk;
      int fc;
   } vec_t;

   vec_t tbl[11];

   initial begin
      tbl[0]  = '{20, 30, 80, 25, 0, 0, 0};
      tbl[1]  = '{20, 30, 80, 25, 0, 0, 1};
      tbl[2]  = '{22, 30, 80, 25, 0, 1, 2};
      tbl[3]  = '{23, 30, 80, 25, 1, 0, 3};
      tbl[4]  = '{18, 28, 82, 23, 1, 0, 4};
      tbl[5]  = '{20, 27, 80, 25, 2, 0, 5};
      tbl[6]  = '{20, 30, 83, 25, 3, 0, 6};
      tbl[7]  = '{20, 30, 80, 28, 3, 0, 7};
      tbl[8]  = '{20, 30, 80, 25, 4, 0, 8};
      tbl[9]  = '{20, 30, 80, 25, 4, 0, 9};
      tbl[10] = '{20, 30, 80, 25, 4, 1, 10};

      reset = 1'b0;
      step(3);
      chk_zero("reset");
      reset = 1'b1;
      step(5);

      for (int i = 0; i < 11; i++) begin
         frame(tbl[i].p, tbl[i].b, tbl[i].a, tbl[i].f);
         chk($sformatf("tbl%0d/err_code", i), int'(err_code), tbl[i].err);
         chk($sformatf("tbl%0d/locked", i), int'(locked), tbl[i].lk);
         chk($sformatf("tbl%0d/frame_count", i), int'(frame_count), tbl[i].fc);
      end

`ifdef VSYNC_MONITOR_ROW_TRACK_EN
      chk("row_valid_span", rv_last_run, AV);
      chk("row_max", rv_last_max, (AV - 1) / LT);
`endif

      for (int i = 0; i < 12; i++) begin
         int p, b, a, f;
         p = PW - TOL - 2 + int'($urandom_range(0, 2 * TOL + 4));
         b = BP - TOL - 2 + int'($urandom_range(0, 2 * TOL + 4));
         a = AV - TOL - 2 + int'($urandom_range(0, 2 * TOL + 4));
         f = FP - TOL - 2 + int'($urandom_range(0, 2 * TOL + 4));
         frame(p, b, a, f);
      end

      // display_active rise inside the vsync pulse
      vsync_in = 1'b0;
      m_vfall();
      step(5);
      display_active_in = 1'b1;
      m_abort(5);
      step(3);
      check_all("illegal");
      chk("illegal/err5", int'(err_code), 5);
      step(5);
      display_active_in = 1'b0;
      step(5);
      vsync_in = 1'b1;
      step(20);
      check_all("seek_idle");

      // vsync fall together with display_active fall
      frame(PW, BP, AV, FP);
      vsync_in = 1'b0;
      m_vfall();
      step(PW);
      vsync_in = 1'b1;
      m_seg(1, PW, PW);
      step(BP);
      display_active_in = 1'b1;
      m_seg(2, BP, BP);
      step(AV);
      vsync_in = 1'b0;
      display_active_in = 1'b0;
      m_abort(5);
      step(3);
      check_all("simul");
      step(10);
      vsync_in = 1'b1;
      step(20);

      // vsync stuck high after a pulse
      vsync_in = 1'b0;
      m_vfall();
      step(PW);
      vsync_in = 1'b1;
      m_seg(1, PW, PW);
      step(3);
      check_all("pre_timeout");
      step(1100);
      m_abort(6);
      check_all("timeout");
      chk("timeout/err6", int'(err_code), 6);

      // lock, then reset in the middle of ACTIVE
      frame(PW, BP, AV, FP);
      frame(PW, BP, AV, FP);
      frame(PW, BP, AV, FP);
      vsync_in = 1'b0;
      m_vfall();
      step(PW);
      vsync_in = 1'b1;
      m_seg(1, PW, PW);
      step(BP);
      display_active_in = 1'b1;
      m_seg(2, BP, BP);
      step(10);
      chk("prereset/locked", int'(locked), 1);
      reset = 1'b0;
      step(1);
      reset = 1'b1;
      m_reset();
      chk_zero("midreset");
      step(AV - 11);
      display_active_in = 1'b0;
      step(FP);
      frame(PW, BP, AV, FP);
      frame(PW, BP, AV, FP);
      frame(PW, BP, AV, FP);
      vsync_in = 1'b0;
      m_vfall();
      step(3);
      check_all("final");
      chk("relock", int'(locked), 1);
      step(5);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/vsync_monitor.md
VSYNC_MONITOR -- requirements
Module: vsync_monitor

Interface
REQ-001 Parameter VSYNC_PULSE_WIDTH_TIME, default 6400, is the expected vsync-low width in clocks.
REQ-002 Parameter BACK_PORCH_TIME, default 92800, is the expected vsync-high, display-inactive time before active video, in clocks.
REQ-003 Parameter ACTIVE_VIDEO_TIME, default 1536000, is the expected display_active-high time in clocks.
REQ-004 Parameter FRONT_PORCH_TIME, default 32000, is the expected time from display_active fall to the next vsync fall, in clocks.
REQ-005 Parameter LINE_TIME, default 16000, is the number of clocks per active row.
REQ-006 Parameter TOLERANCE, default 16, is the allowed plus-or-minus deviation in clocks per segment.
REQ-007 Port clk, input, 1 bit, is the single clock; all logic is on its rising edge.
REQ-008 Port reset, input, 1 bit, is the synchronous, active-low reset.
REQ-009 Port vsync_in, input, 1 bit, is the vsync under test; it is low during the pulse.
REQ-010 Port display_active_in, input, 1 bit, is the display-active signal under test.
REQ-011 Port locked, output, 1 bit, is high after two consecutive in-tolerance frames.
REQ-012 Port frame_done, output, 1 bit, is a 1-cycle pulse at each completed frame.
REQ-013 Port frame_count, output, 8 bits, counts completed frames and wraps.
REQ-014 Port timing_error, output, 1 bit, is a 1-cycle pulse when a segment is out of tolerance or illegal.
REQ-015 Port err_code, output, 3 bits, is the cause of the last error and is held until the next error.
REQ-016 Port row, output, 7 bits, is the recovered active row index.
REQ-017 Port row_valid, output, 1 bit, is high while in ACTIVE.

Function
REQ-018 Inputs SHALL be registered once, and the previous registered values kept, for edge detection; all state decisions SHALL use the registered inputs, giving 2 cycles from pin to state change.
REQ-019 The FSM SHALL have the states SEEK, PULSE, BACK_PORCH, ACTIVE and FRONT_PORCH.
REQ-020 SEEK: on a vsync fall, go to PULSE; no measurement and no error is made in SEEK.
REQ-021 PULSE: on a vsync rise, check the segment counter against VSYNC_PULSE_WIDTH_TIME; go to BACK_PORCH.
REQ-022 BACK_PORCH: on a display_active rise, check against BACK_PORCH_TIME; go to ACTIVE.
REQ-023 ACTIVE: on a display_active fall, check against ACTIVE_VIDEO_TIME; go to FRONT_PORCH.
REQ-024 FRONT_PORCH: on a vsync fall, check against FRONT_PORCH_TIME, pulse frame_done, increment frame_count, go to PULSE.
REQ-025 The 22-bit segment counter SHALL clear on every state transition.
- It counts clocks since the edge that entered the state, so the measured value equals the segment length.
REQ-026 A segment check passes when |count - expected| <= TOLERANCE; both bounds are inclusive.
REQ-027 err_code values:
- 1 = pulse
- 2 = back porch
- 3 = active
- 4 = front porch
- 5 = illegal edge
- 6 = timeout
REQ-028 Illegal edge: a display_active rise in any state other than BACK_PORCH, or a vsync edge while display_active is high, SHALL raise error 5 and go to SEEK.
REQ-029 Timeout: if the counter reaches 2^22-1 in any state other than SEEK, the block SHALL raise error 6 and go to SEEK; the counter saturates in SEEK.
REQ-030 A failed tolerance check SHALL pulse timing_error, continue to the next state, and mark the frame bad.
REQ-031 A frame is good when all four checks pass.
REQ-032 Lock behaviour:
- 2 consecutive good frames set locked.
- Any bad frame, error 5 or error 6 clears locked and zeroes the good-frame count.
REQ-033 Simultaneous vsync fall and display_active fall in ACTIVE SHALL be treated as an illegal edge (error 5).
REQ-034 frame_count SHALL wrap from 255 to 0.

Reset
REQ-035 While reset == 0 at a clk edge, the block SHALL set: state SEEK, counters 0, locked 0, frame_done 0, frame_count 0, timing_error 0, err_code 0, row 0, row_valid 0, edge registers 0.
REQ-036 Reset asserted mid-frame SHALL abandon the frame; after release, the first measured frame starts at the next vsync fall.

Configuration
REQ-037 With VSYNC_MONITOR_ROW_TRACK_EN defined, row SHALL count clocks in ACTIVE and increment after every LINE_TIME clocks.
- row is 0 on ACTIVE entry and saturates at 127.
REQ-038 Without VSYNC_MONITOR_ROW_TRACK_EN, row and row_valid SHALL be tied to 0 and no row counter SHALL be built; all other behaviour is unchanged.

Verification
REQ-039 Nominal frames with default parameters x3 -> frame_done pulses at each vsync fall after the first, locked=1 after the 2nd complete frame, frame_count=3, no timing_error.
REQ-040 Pulse width 6416, then 6417 -> 6416 passes; 6417 gives timing_error with err_code=1 and locked falls to 0.
REQ-041 display_active rise during PULSE -> err_code=5, state SEEK, locked=0, no frame_done until the next full frame.
REQ-042 vsync held high with display_active low for 2^22 clocks after a pulse -> err_code=6, return to SEEK.
REQ-043 Reset low for 1 cycle mid-ACTIVE in a locked stream -> all outputs 0 on the next cycle; relock after 2 further good frames.
REQ-044 With VSYNC_MONITOR_ROW_TRACK_EN defined, nominal ACTIVE -> row reaches 95 before the display_active fall; row_valid spans exactly the ACTIVE state.
